fwd_hazard_unit: RTL and testbench

//  Drives the 2-bit select of both EX-stage ALU operand 3:1 muxes: 0=regfile data, 1=EX/MEM ALU result, 2=MEM/WB writeback data.

---
 rtl/fwd_hazard_unit.sv | 112 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall generation.
// Tracks its own EX/MEM/WB destination shadow, advancing in lockstep with the pipeline registers.
module fwd_hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [15:0]       stall_cnt_o
);

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // EX slot
    logic              ex_v;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_rw;
    logic              ex_mr;
    // MEM and WB slots
    logic              mem_v;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_rw;
    logic              wb_v;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_rw;

    logic mem_writes;
    logic wb_writes;
    logic id_accept;

    // ID->EX transfer: the ID instruction is accepted on any edge where
    // id_valid_i & ~stall_o & ~flush_i; stall_o acts as an inverted ready.
    assign id_accept = id_valid_i & ~stall_o & ~flush_i;

    assign mem_writes = mem_v & mem_rw & (mem_rd != '0);
    assign wb_writes  = wb_v  & wb_rw  & (wb_rd  != '0);

    always_comb begin
        fwd_a_o = SEL_REG;
        fwd_b_o = SEL_REG;
        if (ex_v) begin
            // MEM is checked first so the newest producer wins.
            if (mem_writes && (mem_rd == ex_rs))
                fwd_a_o = SEL_MEM;
            else if (wb_writes && (wb_rd == ex_rs))
                fwd_a_o = SEL_WB;

            if (mem_writes && (mem_rd == ex_rt))
                fwd_b_o = SEL_MEM;
            else if (wb_writes && (wb_rd == ex_rt))
                fwd_b_o = SEL_WB;
        end
    end

    always_comb begin
        stall_o = id_valid_i & ~flush_i & ex_v & ex_mr & (ex_rd != '0)
                & ((ex_rd == id_rs_i) | (ex_rd == id_rt_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_v        <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            mem_v       <= 1'b0;
            mem_rd      <= '0;
            mem_rw      <= 1'b0;
            wb_v        <= 1'b0;
            wb_rd       <= '0;
            wb_rw       <= 1'b0;
            stall_cnt_o <= 16'd0;
        end else begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            wb_rw  <= mem_rw;

            if (id_accept) begin
                ex_v  <= 1'b1;
                ex_rs <= id_rs_i;
                ex_rt <= id_rt_i;
                ex_rd <= id_rd_i;
                ex_rw <= id_regwrite_i;
                ex_mr <= id_memread_i;
            end else begin
                ex_v  <= 1'b0;
            end

            if (stall_o && (stall_cnt_o != 16'hFFFF))
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, r0, flush and reset cases.
module tb_fwd_hazard_unit;

    logic        clk_i;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic [4:0]  id_rd_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        flush_i;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic        stall_o;
    logic [15:0] stall_cnt_o;

    int tests_run;
    int tests_failed;
    logic [3:0] exp_q[$];

    fwd_hazard_unit #(.REG_AW(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rd_i      (id_rd_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i (id_memread_i),
        .flush_i      (flush_i),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled #1 after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic fl);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #1;
    endtask

    task automatic drain();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_fwd: got a=%0d b=%0d expected a=0 b=0", fwd_a_o, fwd_b_o);
        end
        tests_run++;
        if (stall_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_stall: got stall=%0b cnt=%0d expected stall=0 cnt=0", stall_o, stall_cnt_o);
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_ex_mem_fwd();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3,r1,r2
        tick();
        drive_id(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub r4,r3,r1
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_dep_no_stall: got %0b expected 0", stall_o);
        end
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd1 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL ex_mem_fwd: got a=%0d b=%0d expected a=1 b=0", fwd_a_o, fwd_b_o);
        end
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL bubble_fwd_zero: got a=%0d b=%0d expected a=0 b=0", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_mem_wb_fwd();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);   // nop
        tick();
        drive_id(1'b1, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);   // or r5,r1,r3
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd2) begin
            tests_failed++;
            $display("FAIL wb_fwd: got a=%0d b=%0d expected a=0 b=2", fwd_a_o, fwd_b_o);
        end

        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
        tick();
        drive_id(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);   // or r5,r3,r3
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd1 || fwd_b_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL mem_priority: got a=%0d b=%0d expected a=1 b=1", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_load_use();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);   // lw r2,0(r1)
        tick();
        drive_id(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r2,r2
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %0b expected 1", stall_o);
        end
        tick();
        tests_run++;
        if (stall_o !== 1'b0 || stall_cnt_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL stall_one_cycle: got stall=%0b cnt=%0d expected stall=0 cnt=1", stall_o, stall_cnt_o);
        end
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL stall_bubble: got a=%0d b=%0d expected a=0 b=0", fwd_a_o, fwd_b_o);
        end
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd2 || fwd_b_o !== 2'd2 || stall_cnt_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL after_stall_wb: got a=%0d b=%0d cnt=%0d expected a=2 b=2 cnt=1",
                     fwd_a_o, fwd_b_o, stall_cnt_o);
        end

        // Dependency through rt only.
        drain();
        drive_id(1'b1, 5'd1, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0);   // lw r6
        tick();
        drive_id(1'b1, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);   // add r7,r1,r6
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rt_stall: got %0b expected 1", stall_o);
        end
        tick();
        tests_run++;
        if (stall_cnt_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL stall_cnt2: got %0d expected 2", stall_cnt_o);
        end
    endtask

    task automatic test_reg_zero();
        drain();
        drive_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw r0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r0,r0
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0_no_stall: got %0b expected 0", stall_o);
        end
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL r0_load_fwd: got a=%0d b=%0d expected a=0 b=0", fwd_a_o, fwd_b_o);
        end
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);   // add r0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);   // sub r5,r0,r0
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL r0_mem_fwd: got a=%0d b=%0d expected a=0 b=0", fwd_a_o, fwd_b_o);
        end
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (stall_cnt_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL r0_cnt: got %0d expected 2", stall_cnt_o);
        end
    endtask

    task automatic test_flush_and_reset();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);   // lw r2
        tick();
        drive_id(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1);   // dependent add, flushed
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_stall: got %0b expected 0", stall_o);
        end
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0 || stall_cnt_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL flush_bubble: got a=%0d b=%0d cnt=%0d expected a=0 b=0 cnt=2",
                     fwd_a_o, fwd_b_o, stall_cnt_o);
        end

        drain();
        drive_id(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);   // lw r2
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r2,r3
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_stall: got %0b expected 1", stall_o);
        end
        rst_i = 1'b0;
        tick();
        tests_run++;
        if (stall_o !== 1'b0 || stall_cnt_o !== 16'd0 || fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: got stall=%0b cnt=%0d a=%0d b=%0d expected 0 0 0 0",
                     stall_o, stall_cnt_o, fwd_a_o, fwd_b_o);
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rs_t [5] = '{5'd1, 5'd3, 5'd5, 5'd3, 5'd6};
        logic [4:0] rt_t [5] = '{5'd2, 5'd0, 5'd3, 5'd5, 5'd6};
        logic [4:0] rd_t [5] = '{5'd3, 5'd5, 5'd3, 5'd6, 5'd7};
        logic       rw_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_t[5] = '{4'b0000, 4'b0100, 4'b0110, 4'b0010, 4'b0101};
        logic [3:0] exp;
        drain();
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_t[i]);
        for (int i = 0; i < 5; i++) begin
            drive_id(1'b1, rs_t[i], rt_t[i], rd_t[i], rw_t[i], 1'b0, 1'b0);
            tick();
            exp = exp_q.pop_front();
            tests_run++;
            if ({fwd_a_o, fwd_b_o} !== exp || stall_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got a=%0d b=%0d stall=%0b expected a=%0d b=%0d stall=0",
                         i, fwd_a_o, fwd_b_o, stall_o, exp[3:2], exp[1:0]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i        = 1'b0;
        test_reset();
        test_ex_mem_fwd();
        test_mem_wb_fwd();
        test_load_use();
        test_reg_zero();
        test_flush_and_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
